// File: rtl/fsm_seq_counter.sv
// Sequence generator: shows a one-off preamble value after reset, then cycles
// through [BOTTOM..TOP] up or down with load/clamp, wrap pulse and wrap count.
module fsm_seq_counter #(
    parameter int WIDTH    = 4,
    parameter int INIT_VAL = 8,
    parameter int TOP      = 7,
    parameter int BOTTOM   = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cq,
    output logic             wrap,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic             state_o
);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_VAL);
    localparam logic [WIDTH-1:0] TOP_V  = WIDTH'(TOP);
    localparam logic [WIDTH-1:0] BOT_V  = WIDTH'(BOTTOM);

    logic [0:0]       state;
    logic [WIDTH-1:0] load_clamped;
    logic             out_of_range;

    always_comb begin
        load_clamped = load_val;
        if (load_val > TOP_V)
            load_clamped = TOP_V;
        else if (load_val < BOT_V)
            load_clamped = BOT_V;
    end

    // A stray value in S_RUN is recovered by re-entering as if from S_INIT
    assign out_of_range = (cq > TOP_V) || (cq < BOT_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_INIT;
            cq       <= INIT_V;
            wrap     <= 1'b0;
            wrap_cnt <= '0;
        end else if (load) begin
            state <= S_RUN;
            cq    <= load_clamped;
            wrap  <= 1'b0;
        end else if (en) begin
            state <= S_RUN;
            if (state == S_INIT || out_of_range) begin
                cq   <= dir ? BOT_V : TOP_V;
                wrap <= 1'b0;
            end else if (!dir) begin
                if (cq == BOT_V) begin
                    cq       <= TOP_V;
                    wrap     <= 1'b1;
                    wrap_cnt <= wrap_cnt + CNT_W'(1);
                end else begin
                    cq   <= cq - WIDTH'(1);
                    wrap <= 1'b0;
                end
            end else begin
                if (cq == TOP_V) begin
                    cq       <= BOT_V;
                    wrap     <= 1'b1;
                    wrap_cnt <= wrap_cnt + CNT_W'(1);
                end else begin
                    cq   <= cq + WIDTH'(1);
                    wrap <= 1'b0;
                end
            end
        end else begin
            // wrap is a pulse: it drops on any edge that does not wrap
            wrap <= 1'b0;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_fsm_seq_counter.sv
// Bench for fsm_seq_counter: directed scenarios plus random traffic, all
// checked against an arithmetic reference model of the sequence rules.
module tb_fsm_seq_counter;

    localparam int WIDTH = 4, INIT_VAL = 8, TOP = 7, BOTTOM = 1, CNT_W = 8;
    localparam int RANGE = TOP - BOTTOM + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0, en = 1'b0, dir = 1'b0, load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] cq;
    logic             wrap;
    logic [CNT_W-1:0] wrap_cnt;
    logic             state_o;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    int m_cq, m_wrap, m_cnt, m_run;

    fsm_seq_counter #(
        .WIDTH(WIDTH), .INIT_VAL(INIT_VAL), .TOP(TOP), .BOTTOM(BOTTOM), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .cq(cq), .wrap(wrap), .wrap_cnt(wrap_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_tests++;
        assert (obs === 32'(exp))
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input int r, input int ld, input int e, input int d, input int lv);
        if (r != 0) begin
            m_run = 0; m_cq = INIT_VAL; m_wrap = 0; m_cnt = 0;
        end else if (ld != 0) begin
            m_run  = 1;
            m_cq   = (lv > TOP) ? TOP : (lv < BOTTOM) ? BOTTOM : lv;
            m_wrap = 0;
        end else if (e != 0) begin
            if (m_run == 0) begin
                m_cq = (d != 0) ? BOTTOM : TOP;
                m_wrap = 0;
                m_run = 1;
            end else begin
                m_wrap = (d != 0) ? int'(m_cq == TOP) : int'(m_cq == BOTTOM);
                m_cq   = BOTTOM + ((m_cq - BOTTOM + ((d != 0) ? 1 : RANGE - 1)) % RANGE);
                m_cnt  = (m_cnt + m_wrap) % (1 << CNT_W);
            end
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic step(input string tag, input int r, input int ld, input int e,
                        input int d, input int lv);
        rst = (r != 0); load = (ld != 0); en = (e != 0); dir = (d != 0);
        load_val = WIDTH'(lv);
        @(posedge clk);
        #1;
        model(r, ld, e, d, lv);
        chk({tag, ".cq"},    32'(cq),       m_cq);
        chk({tag, ".wrap"},  32'(wrap),     m_wrap);
        chk({tag, ".cnt"},   32'(wrap_cnt), m_cnt);
        chk({tag, ".state"}, 32'(state_o),  m_run);
    endtask

    initial begin
        m_cq = 0; m_wrap = 0; m_cnt = 0; m_run = 0;

        // T1: reset then count down 8,7,...,1,7
        step("t1_rst", 1, 0, 0, 0, 0);
        chk("t1_rst_cq_const", 32'(cq), 8);
        chk("t1_rst_state_const", 32'(state_o), 0);
        for (int i = 0; i < 8; i++) step("t1_dn", 0, 0, 1, 0, 0);
        chk("t1_end_cq_const", 32'(cq), 7);
        chk("t1_end_wrap_const", 32'(wrap), 1);
        chk("t1_end_cnt_const", 32'(wrap_cnt), 1);
        step("t1_idle", 0, 0, 0, 0, 0);
        chk("t1_idle_wrap_const", 32'(wrap), 0);

        // T2: reset then count up 8,1,...,7,1
        step("t2_rst", 1, 0, 0, 1, 0);
        step("t2_first", 0, 0, 1, 1, 0);
        chk("t2_first_cq_const", 32'(cq), 1);
        chk("t2_first_wrap_const", 32'(wrap), 0);
        for (int i = 0; i < 7; i++) step("t2_up", 0, 0, 1, 1, 0);
        chk("t2_end_cq_const", 32'(cq), 1);
        chk("t2_end_cnt_const", 32'(wrap_cnt), 1);

        // T3: en pulses 1,0,0,1 from cq=5
        step("t3_ld", 0, 1, 0, 0, 5);
        step("t3_e1", 0, 0, 1, 0, 0);
        step("t3_e0", 0, 0, 0, 0, 0);
        step("t3_e0", 0, 0, 0, 0, 0);
        step("t3_e1", 0, 0, 1, 0, 0);
        chk("t3_cq_const", 32'(cq), 3);

        // T4: load clamping and load-over-en priority
        step("t4_ld5", 0, 1, 0, 0, 5);
        step("t4_ld12", 0, 1, 0, 0, 12);
        chk("t4_ld12_const", 32'(cq), 7);
        step("t4_ld0", 0, 1, 0, 0, 0);
        chk("t4_ld0_const", 32'(cq), 1);
        step("t4_ld_en", 0, 1, 1, 0, 4);
        chk("t4_ld_en_const", 32'(cq), 4);

        // T5: dir change takes effect on the same edge
        step("t5_ld7", 0, 1, 0, 0, 7);
        step("t5_up", 0, 0, 1, 1, 0);
        step("t5_dn", 0, 0, 1, 0, 0);
        chk("t5_cq_const", 32'(cq), 7);

        // T6: reset mid-run beats load and en, then 256 back-to-back wraps
        step("t6_rst", 1, 1, 1, 0, 3);
        chk("t6_rst_cq_const", 32'(cq), 8);
        chk("t6_rst_cnt_const", 32'(wrap_cnt), 0);
        step("t6_ld1", 0, 1, 0, 0, 1);
        for (int i = 0; i < 256; i++) step("t6_wrap", 0, 0, 1, i % 2, 0);
        chk("t6_cnt_roll_const", 32'(wrap_cnt), 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step("rnd",
                 ($urandom_range(0, 99) < 2) ? 1 : 0,
                 ($urandom_range(0, 99) < 10) ? 1 : 0,
                 ($urandom_range(0, 99) < 70) ? 1 : 0,
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
